// File: rtl/grid_diff_scanner_if.sv
// grid_diff_scanner_if
//   Bundles the signals that connect the cell scanner to its two neighbours:
//   the game logic, which answers cell-flag queries, and the display command
//   engine, which consumes draw commands.
//
//   Parameters
//     GRID_W, GRID_H : playfield size. These set the x/y widths and must match
//                      the scanner instance that uses this bundle.
//
//   Signals (direction as seen from the scanner, which uses the master modport)
//     frame_start   in   1-cycle pulse that starts a scan pass
//     full_redraw   in   sampled together with frame_start
//     snake_head,
//     snake_body,
//     apple, border in   flags for the cell at (x,y), valid LOOKUP_LAT cycles
//                        after x/y change
//     cmd_done      in   display engine accepted the current draw command
//     x, y          out  cell under scan
//     obj_code      out  0 empty, 1 head, 2 body, 3 apple, 4 border
//     cmd_valid     out  draw request for (x, y, obj_code)
//     busy          out  scan pass in progress
//     frame_done    out  1-cycle pulse at the end of a pass
//     diff          out  the last completed pass issued at least one command
//     init_cycle    out  high from reset until the first pass completes
//
//   Handshake: cmd_valid rises with x/y/obj_code already stable and holds all
//   three unchanged until a rising clk edge that sees cmd_valid && cmd_done.
//   That edge transfers the command and drops cmd_valid. cmd_done may already
//   be high in the cycle where cmd_valid rises. cmd_done without cmd_valid
//   has no effect.
interface grid_diff_scanner_if #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12
);
  localparam int X_W = $clog2(GRID_W);
  localparam int Y_W = $clog2(GRID_H);

  logic           frame_start;
  logic           full_redraw;
  logic           snake_head;
  logic           snake_body;
  logic           apple;
  logic           border;
  logic           cmd_done;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     obj_code;
  logic           cmd_valid;
  logic           busy;
  logic           frame_done;
  logic           diff;
  logic           init_cycle;

  // Scanner side.
  modport master (
    input  frame_start, full_redraw,
    input  snake_head, snake_body, apple, border,
    input  cmd_done,
    output x, y, obj_code, cmd_valid,
    output busy, frame_done, diff, init_cycle
  );

  // Game logic and display engine side.
  modport slave (
    output frame_start, full_redraw,
    output snake_head, snake_body, apple, border,
    output cmd_done,
    input  x, y, obj_code, cmd_valid,
    input  busy, frame_done, diff, init_cycle
  );
endinterface

// File: rtl/grid_diff_scanner.sv
// grid_diff_scanner
//   Walks every cell of a GRID_W x GRID_H playfield in raster order. For each
//   cell it asks the game logic for the object flags, reduces them to an
//   object code, and compares that code with a private copy of the last drawn
//   frame. A draw command goes out only for cells whose code changed, or for
//   every cell on the first pass after reset or on a full redraw.
//
//   Parameters
//     GRID_W     : cells per row (>= 2)
//     GRID_H     : rows (>= 2)
//     LOOKUP_LAT : cycles from x/y change to valid flag inputs (0..3)
//
//   Ports
//     clk        : system clock, rising edge
//     rst        : asynchronous active-high reset
//     bus        : grid_diff_scanner_if master side (flags in, commands out)
//     fsm_state  : current FSM state encoding, for observation only
//
//   Timing per cell: LOOKUP_LAT cycles in WAIT, one in EVAL, one in NEXT,
//   plus the ISSUE cycles when a command is sent.
module grid_diff_scanner #(
  parameter int GRID_W     = 16,
  parameter int GRID_H     = 12,
  parameter int LOOKUP_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  grid_diff_scanner_if.master bus,
  output logic [2:0]          fsm_state
);

  localparam int X_W   = $clog2(GRID_W);
  localparam int Y_W   = $clog2(GRID_H);
  localparam int CELLS = GRID_W * GRID_H;
  localparam int A_W   = $clog2(CELLS);

  localparam logic [X_W-1:0] X_LAST    = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_LAST    = Y_W'(GRID_H - 1);
  localparam logic [1:0]     WAIT_LAST = 2'((LOOKUP_LAT > 0) ? LOOKUP_LAT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_EVAL  = 3'd2,
    S_ISSUE = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // With no lookup latency the flags are already valid for the new x/y, so
  // the lookup wait is skipped.
  localparam state_t CELL_ENTRY = (LOOKUP_LAT == 0) ? S_EVAL : S_WAIT;

  state_t         state;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [2:0]     obj_code_q;
  logic           cmd_valid_q;
  logic           busy_q;
  logic           frame_done_q;
  logic           diff_q;
  logic           init_q;
  logic           redraw;     // this pass draws every cell
  logic           pass_diff;  // this pass has issued at least one command
  logic [1:0]     wait_cnt;

  // Last drawn object code per cell. Deliberately not reset: the pass after
  // any reset has init_q set and repaints every cell, which rewrites it.
  logic [2:0]     mem [CELLS];
  logic [A_W-1:0] addr;
  logic [2:0]     code_now;

  assign addr = A_W'(y_q) * A_W'(GRID_W) + A_W'(x_q);

  // Priority: head > body > apple > border > empty.
  always_comb begin
    code_now = 3'd0;
    if (bus.snake_head)      code_now = 3'd1;
    else if (bus.snake_body) code_now = 3'd2;
    else if (bus.apple)      code_now = 3'd3;
    else if (bus.border)     code_now = 3'd4;
  end

  // The frame copy is written on the edge that hands the command over, so it
  // only ever records codes the display engine actually accepted.
  always_ff @(posedge clk) begin
    if (state == S_ISSUE && bus.cmd_done) begin
      mem[addr] <= obj_code_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      obj_code_q   <= 3'd0;
      cmd_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      diff_q       <= 1'b0;
      init_q       <= 1'b1;
      redraw       <= 1'b0;
      pass_diff    <= 1'b0;
      wait_cnt     <= 2'd0;
    end else begin
      case (state)
        // DONE is the frame_done cycle. A new pass may start from it just
        // like from IDLE since busy is already low there.
        S_IDLE, S_DONE: begin
          frame_done_q <= 1'b0;
          if (bus.frame_start) begin
            redraw    <= bus.full_redraw | init_q;
            pass_diff <= 1'b0;
            busy_q    <= 1'b1;
            x_q       <= '0;
            y_q       <= '0;
            wait_cnt  <= 2'd0;
            state     <= CELL_ENTRY;
          end else begin
            state <= S_IDLE;
          end
        end

        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= S_EVAL;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end

        S_EVAL: begin
          obj_code_q <= code_now;
          if (redraw || code_now != mem[addr]) begin
            cmd_valid_q <= 1'b1;
            state       <= S_ISSUE;
          end else begin
            state <= S_NEXT;
          end
        end

        S_ISSUE: begin
          if (bus.cmd_done) begin
            pass_diff   <= 1'b1;
            cmd_valid_q <= 1'b0;
            state       <= S_NEXT;
          end
        end

        S_NEXT: begin
          wait_cnt <= 2'd0;
          if (x_q < X_LAST) begin
            x_q   <= x_q + 1'b1;
            state <= CELL_ENTRY;
          end else if (y_q < Y_LAST) begin
            x_q   <= '0;
            y_q   <= y_q + 1'b1;
            state <= CELL_ENTRY;
          end else begin
            // Last cell finished: x/y stay parked on it until the next pass.
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            diff_q       <= pass_diff;
            init_q       <= 1'b0;
            state        <= S_DONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.obj_code   = obj_code_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.diff       = diff_q;
  assign bus.init_cycle = init_q;
  assign fsm_state      = state;

endmodule

// File: tb/tb_grid_diff_scanner.sv
// tb_grid_diff_scanner
//   Instance a: 16x12, lookup latency 1, driven through a table of passes.
//   Instance b: 10x7, lookup latency 2, asynchronous reset in mid-command.
//   Draw commands are compared against an expected queue built from a
//   reference frame model whenever a pass is started.
module tb_grid_diff_scanner;

  localparam int AW = 16, AH = 12, AL = 1;
  localparam int BW = 10, BH = 7,  BL = 2;
  localparam int SB_W = 11;          // {x[3:0], y[3:0], code[2:0]}
  localparam int TIMEOUT = 20000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [2:0] st_a, st_b;

  grid_diff_scanner_if #(.GRID_W(AW), .GRID_H(AH)) bus_a ();
  grid_diff_scanner_if #(.GRID_W(BW), .GRID_H(BH)) bus_b ();

  grid_diff_scanner #(.GRID_W(AW), .GRID_H(AH), .LOOKUP_LAT(AL)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a), .fsm_state(st_a));
  grid_diff_scanner #(.GRID_W(BW), .GRID_H(BH), .LOOKUP_LAT(BL)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b), .fsm_state(st_b));

  // ---------------- counters / check ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- playfield models ----------------
  // flag bits: [0] head, [1] body, [2] apple, [3] border
  logic [3:0] field_a [AH][AW];
  logic [3:0] field_b [BH][BW];
  logic [2:0] drawn_a [AH][AW];
  logic       init_m_a;

  function automatic logic [2:0] code_of(input logic [3:0] f);
    if (f[0]) return 3'd1;
    if (f[1]) return 3'd2;
    if (f[2]) return 3'd3;
    if (f[3]) return 3'd4;
    return 3'd0;
  endfunction

  // Lookup latency models: flags follow x/y by AL (a) or BL (b) clocks.
  logic [3:0] xa_d, ya_d;
  logic [3:0] xb_d1, xb_d2;
  logic [2:0] yb_d1, yb_d2;
  logic [3:0] flags_a, flags_b;

  always @(posedge clk) begin
    xa_d  <= bus_a.x;
    ya_d  <= bus_a.y;
    xb_d1 <= bus_b.x;
    yb_d1 <= bus_b.y;
    xb_d2 <= xb_d1;
    yb_d2 <= yb_d1;
  end

  always_comb begin
    flags_a = 4'b0;
    if (int'(ya_d) < AH && int'(xa_d) < AW) flags_a = field_a[ya_d][xa_d];
    flags_b = 4'b0;
    if (int'(yb_d2) < BH && int'(xb_d2) < BW) flags_b = field_b[yb_d2][xb_d2];
  end

  assign bus_a.snake_head = flags_a[0];
  assign bus_a.snake_body = flags_a[1];
  assign bus_a.apple      = flags_a[2];
  assign bus_a.border     = flags_a[3];
  assign bus_b.snake_head = flags_b[0];
  assign bus_b.snake_body = flags_b[1];
  assign bus_b.apple      = flags_b[2];
  assign bus_b.border     = flags_b[3];

  // ---------------- scoreboard queues ----------------
  logic [SB_W-1:0] exp_a[$];
  logic [SB_W-1:0] exp_b[$];
  int  delay_a = 3, delay_b = 2;
  bit  spur_a  = 1'b0;
  int  ncmd_a  = 0, ncmd_b = 0;

  // Display engine model a: compares each command, answers after delay_a.
  initial begin : resp_a
    logic [SB_W-1:0] got, e;
    bus_a.cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      bus_a.cmd_done = 1'b0;
      if (bus_a.cmd_valid) begin
        got = {bus_a.x, bus_a.y, bus_a.obj_code};
        ncmd_a++;
        if (exp_a.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL a_cmd_unexpected: got %h, expected no command", got);
        end else begin
          e = exp_a.pop_front();
          check("a_cmd", got, e);
        end
        repeat (delay_a) @(negedge clk);
        check("a_cmd_stable", {bus_a.x, bus_a.y, bus_a.obj_code}, got);
        bus_a.cmd_done = 1'b1;
        @(negedge clk);
        bus_a.cmd_done = 1'b0;
      end else if (spur_a && $urandom_range(0, 3) == 0) begin
        bus_a.cmd_done = 1'b1;  // stray acknowledge outside ISSUE
      end
    end
  end

  initial begin : resp_b
    logic [SB_W-1:0] got, e;
    bus_b.cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      bus_b.cmd_done = 1'b0;
      if (bus_b.cmd_valid) begin
        got = {bus_b.x, 1'b0, bus_b.y, bus_b.obj_code};
        ncmd_b++;
        if (exp_b.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL b_cmd_unexpected: got %h, expected no command", got);
        end else begin
          e = exp_b.pop_front();
          check("b_cmd", got, e);
        end
        repeat (delay_b) @(negedge clk);
        bus_b.cmd_done = 1'b1;
        @(negedge clk);
        bus_b.cmd_done = 1'b0;
      end
    end
  end

  // ---------------- pass table ----------------
  typedef struct {
    logic fr;        // full_redraw at frame_start
    int   dly;       // cmd_done delay after cmd_valid seen
    bit   mid;       // pulse frame_start mid-pass
    bit   spur;      // stray cmd_done pulses
    int   hx, hy;    // head
    int   ax, ay;    // apple
    int   bx, by;    // body at (bx,by),(bx+1,by); bx<0: none
    bit   corner;    // extra head on border cell (0,0)
    int   exp_cmds;
    logic exp_diff;
    int   exp_cyc;   // cycles with busy high
  } vec_t;

  vec_t vecs[6];

  task automatic setup_field_a(input vec_t v);
    for (int yy = 0; yy < AH; yy++)
      for (int xx = 0; xx < AW; xx++)
        field_a[4'(yy)][4'(xx)] = (xx == 0 || xx == AW-1 || yy == 0 || yy == AH-1) ? 4'b1000 : 4'b0000;
    field_a[4'(v.hy)][4'(v.hx)][0] = 1'b1;
    field_a[4'(v.ay)][4'(v.ax)][2] = 1'b1;
    if (v.bx >= 0) begin
      field_a[4'(v.by)][4'(v.bx)][1]     = 1'b1;
      field_a[4'(v.by)][4'(v.bx + 1)][1] = 1'b1;
    end
    if (v.corner) field_a[0][0][0] = 1'b1;
  endtask

  // Reference frame model: push every command the pass must issue.
  task automatic expect_pass_a(input logic fr);
    logic       rd;
    logic [2:0] c;
    rd = fr | init_m_a;
    for (int yy = 0; yy < AH; yy++)
      for (int xx = 0; xx < AW; xx++) begin
        c = code_of(field_a[4'(yy)][4'(xx)]);
        if (rd || c != drawn_a[4'(yy)][4'(xx)]) begin
          exp_a.push_back({4'(xx), 4'(yy), c});
          drawn_a[4'(yy)][4'(xx)] = c;
        end
      end
  endtask

  task automatic run_pass_a(input logic fr, input bit mid, output int cyc,
                            output int mx, output int my, output logic fd_end,
                            output logic fd_after);
    cyc = 0; mx = 0; my = 0;
    @(negedge clk);
    bus_a.frame_start = 1'b1;
    bus_a.full_redraw = fr;
    @(negedge clk);
    while (bus_a.busy && cyc < TIMEOUT) begin
      cyc++;
      if (int'(bus_a.x) > mx) mx = int'(bus_a.x);
      if (int'(bus_a.y) > my) my = int'(bus_a.y);
      bus_a.frame_start = (mid && cyc == 40);
      bus_a.full_redraw = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus_a.frame_start = 1'b0;
    bus_a.full_redraw = 1'b0;
    fd_end = bus_a.frame_done;
    @(negedge clk);
    fd_after = bus_a.frame_done;
  endtask

  task automatic push_all_b();
    for (int yy = 0; yy < BH; yy++)
      for (int xx = 0; xx < BW; xx++)
        exp_b.push_back({4'(xx), 4'(yy), code_of(field_b[3'(yy)][4'(xx)])});
  endtask

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #1000000;
    n_err++;
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int   cyc, mx, my, c0, hit;
    logic fd_end, fd_after;

    vecs[0] = '{1'b0, 3, 1'b0, 1'b0, 4, 4, 7, 4, -1, -1, 1'b0, 192, 1'b1, 1344};
    vecs[1] = '{1'b0, 3, 1'b0, 1'b0, 4, 4, 7, 4, -1, -1, 1'b0,   0, 1'b0,  576};
    vecs[2] = '{1'b0, 3, 1'b0, 1'b0, 5, 4, 7, 4, -1, -1, 1'b0,   2, 1'b1,  584};
    vecs[3] = '{1'b1, 0, 1'b1, 1'b0, 5, 4, 7, 4, -1, -1, 1'b1, 192, 1'b1,  768};
    vecs[4] = '{1'b0, 0, 1'b0, 1'b1, 5, 4, 7, 4, -1, -1, 1'b1,   0, 1'b0,  576};
    vecs[5] = '{1'b0, 1, 1'b0, 1'b0, 5, 4, 0, 5,  4,  4, 1'b1,   3, 1'b1,  582};

    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.frame_start = 1'b0;
    bus_a.full_redraw = 1'b0;
    bus_b.frame_start = 1'b0;
    bus_b.full_redraw = 1'b0;
    init_m_a = 1'b1;
    for (int yy = 0; yy < AH; yy++)
      for (int xx = 0; xx < AW; xx++) drawn_a[4'(yy)][4'(xx)] = 3'd0;
    setup_field_a(vecs[0]);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_x",          bus_a.x,          0);
    check("rst_y",          bus_a.y,          0);
    check("rst_obj_code",   bus_a.obj_code,   0);
    check("rst_cmd_valid",  bus_a.cmd_valid,  0);
    check("rst_busy",       bus_a.busy,       0);
    check("rst_frame_done", bus_a.frame_done, 0);
    check("rst_diff",       bus_a.diff,       0);
    check("rst_init_cycle", bus_a.init_cycle, 1);

    // Table of passes on instance a
    for (int i = 0; i < 6; i++) begin
      setup_field_a(vecs[i]);
      delay_a = vecs[i].dly;
      spur_a  = vecs[i].spur;
      expect_pass_a(vecs[i].fr);
      c0 = ncmd_a;
      run_pass_a(vecs[i].fr, vecs[i].mid, cyc, mx, my, fd_end, fd_after);
      init_m_a = 1'b0;
      spur_a   = 1'b0;
      repeat (6) @(negedge clk);
      check($sformatf("a%0d_no_timeout", i),   (cyc < TIMEOUT), 1);
      check($sformatf("a%0d_cmd_count", i),    ncmd_a - c0, vecs[i].exp_cmds);
      check($sformatf("a%0d_queue_left", i),   exp_a.size(), 0);
      check($sformatf("a%0d_busy_cycles", i),  cyc, vecs[i].exp_cyc);
      check($sformatf("a%0d_diff", i),         bus_a.diff, vecs[i].exp_diff);
      check($sformatf("a%0d_init_cycle", i),   bus_a.init_cycle, 0);
      check($sformatf("a%0d_frame_done", i),   fd_end, 1);
      check($sformatf("a%0d_frame_done_1cyc", i), fd_after, 0);
      check($sformatf("a%0d_max_x", i),        mx, AW - 1);
      check($sformatf("a%0d_max_y", i),        my, AH - 1);
      exp_a.delete();
    end

    // Instance b: asynchronous reset while a command is pending
    for (int yy = 0; yy < BH; yy++)
      for (int xx = 0; xx < BW; xx++)
        field_b[3'(yy)][4'(xx)] = (xx == 0 || xx == BW-1 || yy == 0 || yy == BH-1) ? 4'b1000 : 4'b0000;
    field_b[3][4] = 4'b0100;
    push_all_b();
    @(negedge clk);
    bus_b.frame_start = 1'b1;
    @(negedge clk);
    bus_b.frame_start = 1'b0;
    hit = 0;
    for (int i = 0; i < 5000 && hit == 0; i++) begin
      @(negedge clk);
      if (bus_b.cmd_valid && bus_b.x == 4'd3 && bus_b.y == 3'd2) hit = 1;
    end
    check("b_reached_3_2", hit, 1);
    #2 rst_b = 1'b1;
    #1;
    check("b_rst_cmd_valid",  bus_b.cmd_valid,  0);
    check("b_rst_busy",       bus_b.busy,       0);
    check("b_rst_x",          bus_b.x,          0);
    check("b_rst_y",          bus_b.y,          0);
    check("b_rst_init_cycle", bus_b.init_cycle, 1);
    exp_b.delete();
    @(negedge clk);
    rst_b = 1'b0;
    repeat (10) @(negedge clk);

    push_all_b();
    c0 = ncmd_b;
    mx = 0; my = 0; cyc = 0;
    bus_b.frame_start = 1'b1;
    @(negedge clk);
    bus_b.frame_start = 1'b0;
    while (bus_b.busy && cyc < TIMEOUT) begin
      cyc++;
      if (int'(bus_b.x) > mx) mx = int'(bus_b.x);
      if (int'(bus_b.y) > my) my = int'(bus_b.y);
      @(negedge clk);
    end
    check("b_frame_done",  bus_b.frame_done, 1);
    repeat (6) @(negedge clk);
    check("b_no_timeout",  (cyc < TIMEOUT), 1);
    check("b_cmd_count",   ncmd_b - c0, BW * BH);
    check("b_queue_left",  exp_b.size(), 0);
    check("b_max_x",       mx, BW - 1);
    check("b_max_y",       my, BH - 1);
    check("b_init_cycle",  bus_b.init_cycle, 0);
    check("b_diff",        bus_b.diff, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
